// File: rtl/cmp_persist_monitor.sv
// cmp_persist_monitor
// Watches the one-hot result of a 4-bit magnitude comparator. It counts each
// relation, tracks how long the current relation has persisted, raises an
// alarm after RUN_LEN identical samples and flags malformed codes with a
// sticky error bit.
module cmp_persist_monitor #(
  parameter int CNT_W   = 8,
  parameter int RUN_LEN = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             valid,
  input  logic [2:0]       cmp,
  output logic [CNT_W-1:0] gt_cnt,
  output logic [CNT_W-1:0] eq_cnt,
  output logic [CNT_W-1:0] lt_cnt,
  output logic [3:0]       run_len,
  output logic             alarm,
  output logic [2:0]       alarm_code,
  output logic             err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    ALARM = 2'd2
  } state_t;

  localparam logic [3:0]       RUN_MAX = 4'(RUN_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state_q, state_d;
  logic [CNT_W-1:0] gt_cnt_q, gt_cnt_d;
  logic [CNT_W-1:0] eq_cnt_q, eq_cnt_d;
  logic [CNT_W-1:0] lt_cnt_q, lt_cnt_d;
  logic [3:0]       run_len_q, run_len_d;
  logic [2:0]       last_q, last_d;
  logic             alarm_q, alarm_d;
  logic [2:0]       alarm_code_q, alarm_code_d;
  logic             err_q, err_d;

  logic             one_hot;
  logic             accept;
  logic             malformed;
  logic [3:0]       run_next;

  // Classify the incoming sample; clr suppresses both acceptance and error.
  always_comb begin
    one_hot   = (cmp == 3'b100) || (cmp == 3'b010) || (cmp == 3'b001);
    accept    = valid && !clr && one_hot;
    malformed = valid && !clr && !one_hot;
  end

  // Length the run would have if the current sample is accepted.
  always_comb begin
    run_next = 4'd1;
    if (cmp == last_q) begin
      run_next = (run_len_q < RUN_MAX) ? run_len_q + 4'd1 : RUN_MAX;
    end
  end

  // Next-state logic: counters, run tracking, FSM and alarm outputs.
  always_comb begin
    state_d      = state_q;
    gt_cnt_d     = gt_cnt_q;
    eq_cnt_d     = eq_cnt_q;
    lt_cnt_d     = lt_cnt_q;
    run_len_d    = run_len_q;
    last_d       = last_q;
    alarm_d      = alarm_q;
    alarm_code_d = alarm_code_q;
    err_d        = err_q;

    if (clr) begin
      state_d      = IDLE;
      gt_cnt_d     = '0;
      eq_cnt_d     = '0;
      lt_cnt_d     = '0;
      run_len_d    = 4'd0;
      last_d       = 3'b000;
      alarm_d      = 1'b0;
      alarm_code_d = 3'b000;
      err_d        = 1'b0;
    end else begin
      if (malformed) begin
        err_d = 1'b1;
      end
      if (accept) begin
        if (cmp[2] && gt_cnt_q != CNT_MAX) gt_cnt_d = gt_cnt_q + 1'b1;
        if (cmp[1] && eq_cnt_q != CNT_MAX) eq_cnt_d = eq_cnt_q + 1'b1;
        if (cmp[0] && lt_cnt_q != CNT_MAX) lt_cnt_d = lt_cnt_q + 1'b1;
        run_len_d = run_next;
        last_d    = cmp;
        case (state_q)
          IDLE: begin
            state_d = TRACK;
          end
          TRACK: begin
            if (run_next == RUN_MAX) begin
              state_d      = ALARM;
              alarm_d      = 1'b1;
              alarm_code_d = cmp;
            end
          end
          ALARM: begin
            if (cmp != last_q) begin
              state_d      = TRACK;
              alarm_d      = 1'b0;
              alarm_code_d = 3'b000;
            end
          end
          default: begin
            state_d = IDLE;
          end
        endcase
      end
    end
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      gt_cnt_q     <= '0;
      eq_cnt_q     <= '0;
      lt_cnt_q     <= '0;
      run_len_q    <= 4'd0;
      last_q       <= 3'b000;
      alarm_q      <= 1'b0;
      alarm_code_q <= 3'b000;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      gt_cnt_q     <= gt_cnt_d;
      eq_cnt_q     <= eq_cnt_d;
      lt_cnt_q     <= lt_cnt_d;
      run_len_q    <= run_len_d;
      last_q       <= last_d;
      alarm_q      <= alarm_d;
      alarm_code_q <= alarm_code_d;
      err_q        <= err_d;
    end
  end

  assign gt_cnt     = gt_cnt_q;
  assign eq_cnt     = eq_cnt_q;
  assign lt_cnt     = lt_cnt_q;
  assign run_len    = run_len_q;
  assign alarm      = alarm_q;
  assign alarm_code = alarm_code_q;
  assign err        = err_q;

endmodule

// File: tb/tb_cmp_persist_monitor.sv
// Testbench for cmp_persist_monitor. A behavioural model keeps plain integer
// counts and the true (unsaturated) run length; the outputs are derived from
// those with min() and threshold rules and compared on every falling edge.
module tb_cmp_persist_monitor;

  localparam int CNT_W   = 2;
  localparam int RUN_LEN = 4;
  localparam int CNT_SAT = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst_n;
  logic             clr;
  logic             valid;
  logic [2:0]       cmp;
  logic [CNT_W-1:0] gt_cnt;
  logic [CNT_W-1:0] eq_cnt;
  logic [CNT_W-1:0] lt_cnt;
  logic [3:0]       run_len;
  logic             alarm;
  logic [2:0]       alarm_code;
  logic             err;

  int vectors = 0;
  int miscompares = 0;

  // Behavioural model state.
  int         mGt, mEq, mLt, mRun;
  logic [2:0] mLast;
  bit         mErr;

  cmp_persist_monitor #(.CNT_W(CNT_W), .RUN_LEN(RUN_LEN)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (clr),
    .valid      (valid),
    .cmp        (cmp),
    .gt_cnt     (gt_cnt),
    .eq_cnt     (eq_cnt),
    .lt_cnt     (lt_cnt),
    .run_len    (run_len),
    .alarm      (alarm),
    .alarm_code (alarm_code),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int minInt(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic bit isOneHot(input logic [2:0] c);
    return (c == 3'b100) || (c == 3'b010) || (c == 3'b001);
  endfunction

  function automatic int expAlarm();
    return (mRun >= RUN_LEN) ? 1 : 0;
  endfunction

  function automatic int expCode();
    return (mRun >= RUN_LEN) ? int'(mLast) : 0;
  endfunction

  task automatic modelReset();
    mGt = 0; mEq = 0; mLt = 0; mRun = 0; mLast = 3'b000; mErr = 1'b0;
  endtask

  task automatic modelStep(input bit v, input logic [2:0] c, input bit cl);
    if (cl) begin
      modelReset();
    end else if (v) begin
      if (!isOneHot(c)) begin
        mErr = 1'b1;
      end else begin
        if (c == 3'b100) mGt++;
        if (c == 3'b010) mEq++;
        if (c == 3'b001) mLt++;
        if (c == mLast) mRun++;
        else begin
          mRun  = 1;
          mLast = c;
        end
      end
    end
  endtask

  task automatic checkOutput(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Drive one cycle of stimulus and advance the model on the same edge.
  task automatic applyStimulus(input bit v, input logic [2:0] c, input bit cl);
    valid = v;
    cmp   = c;
    clr   = cl;
    @(posedge clk);
    modelStep(v, c, cl);
    #1;
  endtask

  // Asynchronous reset asserted mid-cycle, held for two edges.
  task automatic doReset();
    valid = 1'b0; cmp = 3'b000; clr = 1'b0;
    #2;
    rst_n = 1'b0;
    modelReset();
    #1;
    checkOutput("async_rst_alarm", int'(alarm), 0);
    checkOutput("async_rst_err", int'(err), 0);
    checkOutput("async_rst_run", int'(run_len), 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Compare process: every falling edge the DUT must match the model.
  always @(negedge clk) begin
    checkOutput("gt_cnt", int'(gt_cnt), minInt(mGt, CNT_SAT));
    checkOutput("eq_cnt", int'(eq_cnt), minInt(mEq, CNT_SAT));
    checkOutput("lt_cnt", int'(lt_cnt), minInt(mLt, CNT_SAT));
    checkOutput("run_len", int'(run_len), minInt(mRun, RUN_LEN));
    checkOutput("alarm", int'(alarm), expAlarm());
    checkOutput("alarm_code", int'(alarm_code), expCode());
    checkOutput("err", int'(err), int'(mErr));
  end

  logic [2:0] prevCode;
  logic [2:0] rc;
  int         r;

  initial begin
    rst_n = 1'b0; clr = 1'b0; valid = 1'b0; cmp = 3'b000;
    modelReset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 3'b000, 1'b0);
    checkOutput("idle_gt", int'(gt_cnt), 0);
    checkOutput("idle_run", int'(run_len), 0);
    checkOutput("idle_alarm", int'(alarm), 0);

    // Counting
    applyStimulus(1'b1, 3'b100, 1'b0);
    applyStimulus(1'b1, 3'b001, 1'b0);
    applyStimulus(1'b1, 3'b010, 1'b0);
    applyStimulus(1'b1, 3'b100, 1'b0);
    checkOutput("count_gt", int'(gt_cnt), 2);
    checkOutput("count_eq", int'(eq_cnt), 1);
    checkOutput("count_lt", int'(lt_cnt), 1);
    checkOutput("count_run", int'(run_len), 1);
    checkOutput("count_alarm", int'(alarm), 0);

    // Persistence
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 3'b010, 1'b0);
    checkOutput("pre_alarm", int'(alarm), 0);
    applyStimulus(1'b1, 3'b010, 1'b0);
    checkOutput("alarm_rise", int'(alarm), 1);
    checkOutput("alarm_code", int'(alarm_code), 2);
    checkOutput("alarm_run", int'(run_len), 4);
    checkOutput("eq_saturated", int'(eq_cnt), 3);
    applyStimulus(1'b1, 3'b010, 1'b0);
    checkOutput("alarm_hold", int'(alarm), 1);
    applyStimulus(1'b1, 3'b100, 1'b0);
    checkOutput("alarm_drop", int'(alarm), 0);
    checkOutput("alarm_code_drop", int'(alarm_code), 0);
    checkOutput("drop_run", int'(run_len), 1);

    // Error mid-run
    applyStimulus(1'b0, 3'b000, 1'b1);
    applyStimulus(1'b1, 3'b001, 1'b0);
    applyStimulus(1'b1, 3'b001, 1'b0);
    applyStimulus(1'b1, 3'b110, 1'b0);
    checkOutput("err_set", int'(err), 1);
    checkOutput("err_lt", int'(lt_cnt), 2);
    checkOutput("err_run", int'(run_len), 2);
    applyStimulus(1'b1, 3'b001, 1'b0);
    checkOutput("err_run_next", int'(run_len), 3);
    checkOutput("err_sticky", int'(err), 1);

    // Saturation, ending in ALARM
    applyStimulus(1'b0, 3'b000, 1'b1);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 3'b100, 1'b0);
    checkOutput("sat_gt", int'(gt_cnt), 3);
    checkOutput("sat_alarm", int'(alarm), 1);

    // clr priority over valid during ALARM
    applyStimulus(1'b1, 3'b100, 1'b1);
    checkOutput("clr_gt", int'(gt_cnt), 0);
    checkOutput("clr_alarm", int'(alarm), 0);
    checkOutput("clr_run", int'(run_len), 0);
    applyStimulus(1'b1, 3'b001, 1'b0);
    checkOutput("after_clr_run", int'(run_len), 1);
    checkOutput("after_clr_lt", int'(lt_cnt), 1);

    // Invalid code while in ALARM
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 3'b010, 1'b0);
    applyStimulus(1'b1, 3'b111, 1'b0);
    checkOutput("inv_alarm_hold", int'(alarm), 1);
    checkOutput("inv_alarm_err", int'(err), 1);
    checkOutput("inv_alarm_code", int'(alarm_code), 2);

    // Asynchronous reset mid-run
    doReset();

    // Randomized stimulus
    prevCode = 3'b100;
    for (int i = 0; i < 2000; i++) begin
      if (i % 700 == 699) doReset();
      r = int'($urandom_range(0, 99));
      if (r < 8) begin
        rc = 3'($urandom_range(0, 7));
      end else if (r < 65) begin
        rc = prevCode;
      end else begin
        case ($urandom_range(0, 2))
          0:       rc = 3'b100;
          1:       rc = 3'b010;
          default: rc = 3'b001;
        endcase
      end
      if (isOneHot(rc)) prevCode = rc;
      applyStimulus(($urandom_range(0, 9) != 0), rc, ($urandom_range(0, 59) == 0));
    end

    @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
